stopwatch_timer_core: RTL and testbench
=======================================

# stopwatch_timer_core

Parametrised stopwatch/timer core that merges the run/pause control state machine with its own prescaler, count register and lap capture. It supports up-counting with wrap and down-counting with expiry, and sits between the debounced button pulses and the display/formatting logic. It replaces the separate control FSM + external counter pairing for new timer channels.

## Interface
- CNT_W, 16: width of count, load_val and lap_val (≥2)
- TICK_DIV, 1000: clk cycles per count step (≥1; 1 = step every cycle)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request: run/resume
- stop  in  1  single-cycle request: pause
- reset  in  1  single-cycle request: synchronous return to IDLE
- lap  in  1  single-cycle request: capture current count
- mode_down  in  1  0 = up-count, 1 = down-count; sampled only on start from IDLE
- load_val  in  CNT_W  down-count start value; sampled on start from IDLE or EXPIRED
- count  out  CNT_W  current count register
- lap_val  out  CNT_W  last captured count
- lap_valid  out  1  one-cycle pulse, lap_val updated
- wrap  out  1  one-cycle pulse, up-count rolled over max→0
- expired  out  1  one-cycle pulse, entry into EXPIRED
- status  out  2  present state encoding

## Operation
- States: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10, EXPIRED=2'b11; status = present state (registered).
- Request priority in every state: reset > stop > start. lap is evaluated independently, but is suppressed when reset is asserted.
- IDLE:
  - count held at 0; prescaler cleared.
  - start → RUNNING; latch mode_down into internal dir.
  - If dir=1, count ← load_val.
  - If dir=1 and load_val==0 → EXPIRED instead of RUNNING.
- RUNNING:
  - Prescaler advances. A tick occurs when prescaler==TICK_DIV-1; the prescaler returns to 0 on that edge.
  - On tick with dir=0: count+1. At all-ones, count wraps to 0 and wrap pulses.
  - On tick with dir=1: count-1. Going 1→0 transitions to EXPIRED and pulses expired.
  - reset → IDLE; stop → PAUSED.
- PAUSED:
  - count and prescaler held. The prescaler is not cleared, so a resume completes the partial period.
  - reset → IDLE; start → RUNNING.
- EXPIRED:
  - count held at 0; prescaler cleared.
  - reset → IDLE.
  - start → RUNNING with count ← load_val and dir kept at 1. If load_val==0, stay EXPIRED and pulse expired again.
  - stop is ignored.
- Count update is governed by the present state. A tick in the same cycle as stop is still applied; the pause takes effect from the next cycle.
- reset (synchronous request) → IDLE next edge: count ← 0, prescaler ← 0. lap_val is retained.
- lap:
  - Honoured in RUNNING and PAUSED only: lap_val ← count as it was before this edge's update; lap_valid=1 for one cycle.
  - Ignored in IDLE and EXPIRED.
- mode_down changes outside the start-from-IDLE cycle have no effect.

## Timing
- Asynchronous rst_n low forces: state IDLE, status=0, count=0, lap_val=0, lap_valid=0, wrap=0, expired=0, prescaler=0, dir=0.
- All outputs are registered; no combinational input→output paths.
- Latency:
  - start in IDLE → status=RUNNING one clk later.
  - First tick occurs TICK_DIV cycles after entering RUNNING.
  - The count change is visible the same edge as the tick.
- The wrap and expired pulses are asserted in the cycle after the edge that changes count, aligned with the new count value.
- Requests are one-cycle pulses. A held level re-applies each cycle, with no edge detection inside the block.

## Test plan
- CNT_W=8, TICK_DIV=4:
  - rst_n low mid-run → all outputs 0 and status=0 immediately.
  - Then start → status=01 at next edge, count=1 after 4 cycles, count=5 after 20 cycles.
- Up wrap, TICK_DIV=1, count=8'hFE: two cycles running → count 8'hFF then 8'h00, with wrap=1 for exactly one cycle.
- Down mode, load_val=3, TICK_DIV=2:
  - start → count=3, 2, 1, 0 on alternating cycles.
  - status=11 and expired=1 for one cycle at 0; count holds 0.
  - Second start → count=3, status=01.
- Pause/resume, TICK_DIV=4: stop after 2 prescaler cycles → count frozen 10 cycles; start → next tick occurs 2 cycles after resume, not 4.
- Lap and simultaneity:
  - lap at count=7 while running → lap_val=7, lap_valid pulse 1 cycle.
  - lap+reset same cycle → lap_valid stays 0; status=00, count=0, lap_val still 7.
- Priority:
  - stop+start in RUNNING → PAUSED.
  - reset+start in PAUSED → IDLE.
  - start with mode_down=1, load_val=0 → EXPIRED directly, expired pulse.

Source files
------------

// File: rtl/stopwatch_timer_core.sv
// ============================================================================
// stopwatch_timer_core : run/pause stopwatch with prescaler, wrap/expiry, lap
// Revision 1.0
// ============================================================================
`default_nettype none

module stopwatch_timer_core #(
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             lap,
    input  logic             mode_down,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] lap_val,
    output logic             lap_valid,
    output logic             wrap,
    output logic             expired,
    output logic [1:0]       status
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    localparam int                C_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_PRE_W-1:0] C_PRE_LAST = C_PRE_W'(TICK_DIV - 1);
    localparam logic [C_PRE_W-1:0] C_PRE_ONE  = C_PRE_W'(1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [C_PRE_W-1:0] presc_q, presc_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   lap_val_q, lap_val_d;
    logic               lap_valid_q, lap_valid_d;
    logic               wrap_q, wrap_d;
    logic               expired_q, expired_d;

    logic w_tick;
    logic w_go;
    logic w_last_down;

    assign w_tick      = (presc_q == C_PRE_LAST);
    // stop outranks start in every state
    assign w_go        = start & ~stop;
    assign w_last_down = w_tick & dir_q & (count_q == C_CNT_ONE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_d     = presc_q;
        dir_d       = dir_q;
        lap_val_d   = lap_val_q;
        lap_valid_d = 1'b0;
        wrap_d      = 1'b0;
        expired_d   = 1'b0;

        // lap samples the count as it stood before this edge's update
        if (lap && !reset && (state_q == ST_RUNNING || state_q == ST_PAUSED)) begin
            lap_val_d   = count_q;
            lap_valid_d = 1'b1;
        end

        if (reset) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    presc_d = '0;
                    if (w_go) begin
                        dir_d = mode_down;
                        if (mode_down) begin
                            count_d = load_val;
                            if (load_val == '0) begin
                                state_d   = ST_EXPIRED;
                                expired_d = 1'b1;
                            end else begin
                                state_d = ST_RUNNING;
                            end
                        end else begin
                            state_d = ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (w_tick) begin
                        presc_d = '0;
                        if (dir_q) begin
                            count_d = count_q - C_CNT_ONE;
                            if (w_last_down) begin
                                state_d   = ST_EXPIRED;
                                expired_d = 1'b1;
                            end
                        end else begin
                            count_d = count_q + C_CNT_ONE;
                            wrap_d  = &count_q;
                        end
                    end else begin
                        presc_d = presc_q + C_PRE_ONE;
                    end
                    // reaching zero on the same edge as stop still expires
                    if (stop && !w_last_down) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (w_go) begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_EXPIRED: begin
                    count_d = '0;
                    presc_d = '0;
                    if (w_go) begin
                        if (load_val == '0) begin
                            expired_d = 1'b1;
                        end else begin
                            count_d = load_val;
                            state_d = ST_RUNNING;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            presc_q     <= '0;
            dir_q       <= 1'b0;
            lap_val_q   <= '0;
            lap_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            dir_q       <= dir_d;
            lap_val_q   <= lap_val_d;
            lap_valid_q <= lap_valid_d;
            wrap_q      <= wrap_d;
            expired_q   <= expired_d;
        end
    end

    assign count     = count_q;
    assign lap_val   = lap_val_q;
    assign lap_valid = lap_valid_q;
    assign wrap      = wrap_q;
    assign expired   = expired_q;
    assign status    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_timer_core.sv
// ============================================================================
// tb_stopwatch_timer_core : directed + random bench against a behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_timer_core;

    localparam int CNT_W    = 4;
    localparam int TICK_DIV = 3;
    localparam int CNT_MOD  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, reset, lap, mode_down;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count, lap_val;
    logic             lap_valid, wrap, expired;
    logic [1:0]       status;

    stopwatch_timer_core #(.CNT_W(CNT_W), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
        .lap(lap), .mode_down(mode_down), .load_val(load_val),
        .count(count), .lap_val(lap_val), .lap_valid(lap_valid),
        .wrap(wrap), .expired(expired), .status(status)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: m_phase counts cycles spent running since last step.
    int m_state, m_count, m_phase, m_lap_val;
    bit m_dir, m_lap_valid, m_wrap, m_expired;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_count = 0; m_phase = 0; m_lap_val = 0;
        m_dir = 0; m_lap_valid = 0; m_wrap = 0; m_expired = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit rs, input bit lp,
                              input bit md, input int lv);
        bit go;
        go = st && !sp;
        m_lap_valid = 0; m_wrap = 0; m_expired = 0;
        if (lp && !rs && (m_state == 1 || m_state == 2)) begin
            m_lap_val = m_count;
            m_lap_valid = 1;
        end
        if (rs) begin
            m_state = 0; m_count = 0; m_phase = 0;
        end else if (m_state == 0) begin
            if (go) begin
                m_dir = md;
                if (md && lv == 0) begin
                    m_state = 3; m_expired = 1;
                end else begin
                    m_state = 1;
                    m_count = md ? lv : 0;
                end
            end
        end else if (m_state == 1) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                if (m_dir) begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_state = 3; m_expired = 1;
                    end
                end else begin
                    m_count = (m_count + 1) % CNT_MOD;
                    if (m_count == 0) m_wrap = 1;
                end
            end
            if (sp && m_state == 1) m_state = 2;
        end else if (m_state == 2) begin
            if (go) m_state = 1;
        end else begin
            if (go) begin
                if (lv == 0) m_expired = 1;
                else begin
                    m_count = lv; m_state = 1; m_phase = 0;
                end
            end
        end
    endtask

    // Per-cycle comparison against the model, just after each active edge
    always @(posedge clk) begin
        #1;
        chk("status", 32'(status), 32'(m_state));
        chk("count", 32'(count), 32'(m_count));
        chk("lap_val", 32'(lap_val), 32'(m_lap_val));
        chk("lap_valid", 32'(lap_valid), 32'(m_lap_valid));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("expired", 32'(expired), 32'(m_expired));
    end

    task automatic cyc(input bit st, input bit sp, input bit rs, input bit lp,
                       input bit md, input int lv);
        @(negedge clk);
        start = st; stop = sp; reset = rs; lap = lp; mode_down = md;
        load_val = CNT_W'(lv);
        model_step(st, sp, rs, lp, md, lv);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; reset = 0; lap = 0; mode_down = 0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_status", 32'(status), 0);
        chk("rst_count", 32'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up-count latency
        cyc(1, 0, 0, 0, 0, 0);
        chk("up_start_status", 32'(status), 1);
        chk("up_start_count", 32'(count), 0);
        idle(3);
        chk("up_first_tick", 32'(count), 1);
        idle(12);
        chk("up_count5", 32'(count), 5);

        // Asynchronous reset mid-run
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_status", 32'(status), 0);
        chk("arst_count", 32'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lap capture, then lap suppressed by reset
        cyc(1, 0, 0, 0, 0, 0);
        idle(21);
        chk("lap_pre_count", 32'(count), 7);
        cyc(0, 0, 0, 1, 0, 0);
        chk("lap_val", 32'(lap_val), 7);
        chk("lap_valid_pulse", 32'(lap_valid), 1);
        idle(1);
        chk("lap_valid_drop", 32'(lap_valid), 0);
        cyc(0, 0, 1, 1, 0, 0);
        chk("lapreset_valid", 32'(lap_valid), 0);
        chk("lapreset_status", 32'(status), 0);
        chk("lapreset_count", 32'(count), 0);
        chk("lapreset_lapval", 32'(lap_val), 7);

        // Pause mid-period, resume finishes the partial period
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("pause_status", 32'(status), 2);
        idle(10);
        chk("pause_frozen", 32'(count), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("resume_count", 32'(count), 0);
        idle(1);
        chk("resume_tick", 32'(count), 1);

        // Priority
        cyc(1, 1, 0, 0, 0, 0);
        chk("stop_over_start", 32'(status), 2);
        cyc(1, 0, 1, 0, 0, 0);
        chk("reset_over_start", 32'(status), 0);

        // Down-count to expiry and restart
        cyc(1, 0, 0, 0, 1, 3);
        chk("down_load", 32'(count), 3);
        idle(3);
        chk("down_2", 32'(count), 2);
        idle(6);
        chk("down_0", 32'(count), 0);
        chk("down_exp_status", 32'(status), 3);
        chk("down_exp_pulse", 32'(expired), 1);
        idle(1);
        chk("down_exp_drop", 32'(expired), 0);
        chk("down_hold", 32'(count), 0);
        cyc(1, 0, 0, 0, 0, 3);
        chk("restart_count", 32'(count), 3);
        chk("restart_status", 32'(status), 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("zero_load_status", 32'(status), 3);
        chk("zero_load_exp", 32'(expired), 1);
        cyc(0, 0, 1, 0, 0, 0);

        // Up wrap
        cyc(1, 0, 0, 0, 0, 0);
        idle(47);
        chk("wrap_pre", 32'(count), 15);
        idle(1);
        chk("wrap_count", 32'(count), 0);
        chk("wrap_pulse", 32'(wrap), 1);
        idle(1);
        chk("wrap_drop", 32'(wrap), 0);
        cyc(0, 0, 1, 0, 0, 0);

        // Random traffic; start and stop never coincide here
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit st, sp, rs, lp, md;
            int lv;
            r  = int'($urandom_range(0, 99));
            st = (r < 12);
            sp = (r >= 12 && r < 20);
            rs = ($urandom_range(0, 99) < 3);
            lp = ($urandom_range(0, 9) == 0);
            md = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
            cyc(st, sp, rs, lp, md, lv);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
